ascon_aead128a_ctrl: RTL

- Sequencer for Ascon-128a authenticated encryption around the multicycle permutation core `ascon_permutation_multicycle_p4`.
- Owns the 320-bit state register and performs the initialization, associated data (AD) absorb, plaintext encrypt and finalization phases.
- Drives the core's p12/p8 enables and waits for its `done`.
- Block streams enter and leave on valid/ready handshakes.

---
 rtl/ascon_aead128a_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ascon_aead128a_ctrl.sv
// ascon_aead128a_ctrl
//   Ascon-128a AEAD sequencer wrapped around an external multicycle
//   permutation core. Holds the 320-bit state {x0,x1,x2,x3,x4}. Runs the
//   initialization, associated-data absorb, plaintext encrypt and
//   finalization phases. Block streams use valid/ready handshakes.
//
// Optional build macro: ASCON_DECRYPT_EN adds the `decrypt` input. When it
//   is set, ct_data carries recovered plaintext and the rate is overwritten
//   with the incoming ciphertext.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, key, nonce,       operation launch; sampled only in IDLE
//   has_ad (, decrypt)
//   ad_valid/ad_ready,       pre-padded associated data blocks
//   ad_data, ad_last
//   pt_valid/pt_ready,       pre-padded plaintext blocks
//   pt_data, pt_last
//   ct_valid/ct_ready,       ciphertext blocks, held stable while stalled
//   ct_data
//   tag_valid, tag           one-cycle tag pulse; tag held until next start
//   busy, err                FSM not idle; sticky watchdog error
//   perm_en_p12/perm_en_p8   permutation request (round count select)
//   perm_s_o/perm_s_i        state to/from the core; perm_done completion
module ascon_aead128a_ctrl #(
    parameter logic [63:0] IV          = 64'h80800c0800000000,
    parameter int unsigned WDOG_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic         has_ad,
`ifdef ASCON_DECRYPT_EN
    input  logic         decrypt,
`endif
    input  logic         ad_valid,
    output logic         ad_ready,
    input  logic [127:0] ad_data,
    input  logic         ad_last,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [127:0] pt_data,
    input  logic         pt_last,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [127:0] ct_data,
    output logic         tag_valid,
    output logic [127:0] tag,
    output logic         busy,
    output logic         err,
    output logic         perm_en_p12,
    output logic         perm_en_p8,
    output logic [319:0] perm_s_o,
    input  logic [319:0] perm_s_i,
    input  logic         perm_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_P, S_AD_WAIT, S_AD_P, S_DSEP,
        S_PT_WAIT, S_CT_OUT, S_PT_P, S_FIN_P
    } state_t;

    localparam int unsigned WDOG_LIM = (WDOG_CYCLES == 0) ? 1 : WDOG_CYCLES;

    state_t         state_q, state_d;
    logic [319:0]   s_q, s_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   tag_q, tag_d;
    logic           has_ad_q, has_ad_d;
    logic           ad_last_q, ad_last_d;
    logic           pt_last_q, pt_last_d;
    logic           tag_valid_q, tag_valid_d;
    logic           err_q, err_d;
    logic [31:0]    wdog_q, wdog_d;
`ifdef ASCON_DECRYPT_EN
    logic           dec_q, dec_d;
`endif

    logic           perm_active;
    logic           wdog_expire;
    logic [127:0]   c_blk;

    assign perm_active = (state_q == S_INIT_P) || (state_q == S_AD_P) ||
                         (state_q == S_PT_P)   || (state_q == S_FIN_P);
    // Count only cycles spent waiting; a done in the final allowed cycle wins.
    assign wdog_expire = (WDOG_CYCLES != 0) && perm_active && !perm_done &&
                         (wdog_q == 32'(WDOG_LIM - 1));
    assign c_blk       = s_q[319:192] ^ pt_data;

    // Requests decode straight from the state register so an asynchronous
    // reset removes them immediately.
    assign perm_en_p12 = (state_q == S_INIT_P) || (state_q == S_FIN_P);
    assign perm_en_p8  = (state_q == S_AD_P)   || (state_q == S_PT_P);
    assign perm_s_o    = s_q;
    assign ad_ready    = (state_q == S_AD_WAIT);
    assign pt_ready    = (state_q == S_PT_WAIT);
    assign ct_valid    = (state_q == S_CT_OUT);
    assign ct_data     = ct_q;
    assign tag_valid   = tag_valid_q;
    assign tag         = tag_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        key_d       = key_q;
        ct_d        = ct_q;
        tag_d       = tag_q;
        has_ad_d    = has_ad_q;
        ad_last_d   = ad_last_q;
        pt_last_d   = pt_last_q;
        tag_valid_d = 1'b0;
        err_d       = err_q;
        wdog_d      = (perm_active && !perm_done) ? wdog_q + 32'd1 : 32'd0;
`ifdef ASCON_DECRYPT_EN
        dec_d       = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d      = {IV, key, nonce};
                    key_d    = key;
                    has_ad_d = has_ad;
                    err_d    = 1'b0;
                    tag_d    = '0;
`ifdef ASCON_DECRYPT_EN
                    dec_d    = decrypt;
`endif
                    state_d  = S_INIT_P;
                end
            end
            S_INIT_P: begin
                if (perm_done) begin
                    s_d     = perm_s_i ^ {192'b0, key_q};
                    state_d = has_ad_q ? S_AD_WAIT : S_DSEP;
                end
            end
            S_AD_WAIT: begin
                if (ad_valid) begin
                    s_d[319:192] = s_q[319:192] ^ ad_data;
                    ad_last_d    = ad_last;
                    state_d      = S_AD_P;
                end
            end
            S_AD_P: begin
                if (perm_done) begin
                    s_d     = perm_s_i;
                    state_d = ad_last_q ? S_DSEP : S_AD_WAIT;
                end
            end
            S_DSEP: begin
                s_d[0]  = ~s_q[0];
                state_d = S_PT_WAIT;
            end
            S_PT_WAIT: begin
                if (pt_valid) begin
`ifdef ASCON_DECRYPT_EN
                    // Decryption continues from the received ciphertext.
                    s_d[319:192] = dec_q ? pt_data : c_blk;
`else
                    s_d[319:192] = c_blk;
`endif
                    ct_d      = c_blk;
                    pt_last_d = pt_last;
                    state_d   = S_CT_OUT;
                end
            end
            S_CT_OUT: begin
                if (ct_ready) begin
                    if (pt_last_q) begin
                        // Key goes into x2,x3 ahead of the final p12.
                        s_d[191:64] = s_q[191:64] ^ key_q;
                        state_d     = S_FIN_P;
                    end else begin
                        state_d = S_PT_P;
                    end
                end
            end
            S_PT_P: begin
                if (perm_done) begin
                    s_d     = perm_s_i;
                    state_d = S_PT_WAIT;
                end
            end
            S_FIN_P: begin
                if (perm_done) begin
                    s_d         = perm_s_i;
                    tag_d       = perm_s_i[127:0] ^ key_q;
                    tag_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wdog_expire) begin
            err_d       = 1'b1;
            tag_valid_d = 1'b0;
            wdog_d      = 32'd0;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            tag_q       <= '0;
            has_ad_q    <= 1'b0;
            ad_last_q   <= 1'b0;
            pt_last_q   <= 1'b0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
`ifdef ASCON_DECRYPT_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            tag_q       <= tag_d;
            has_ad_q    <= has_ad_d;
            ad_last_q   <= ad_last_d;
            pt_last_q   <= pt_last_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
`ifdef ASCON_DECRYPT_EN
            dec_q       <= dec_d;
`endif
        end
    end

endmodule
